// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch handshake: req/addr toward memory, ready/rdata back.
interface pc_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch.sv
// PC register and fetch stage with a registered IF/ID output and one-entry skid buffer.
// Optional FETCH_STAT_EN adds fetch_count / stall_cycles statistics outputs.
module pc_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       PC_next,
   input  logic              stall,
   input  logic              flush,
   pc_fetch_if.master        imem,
   output logic [31:0]       PC,
   output logic [31:0]       PC_plus4,
   output logic [31:0]       instr_out,
   output logic [31:0]       instr_pc,
   output logic              instr_valid
`ifdef FETCH_STAT_EN
   ,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_cycles
`endif
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;

   state_t      state, state_nx;
   logic [31:0] pc_nx, out_nx, ipc_nx;
   logic        valid_nx;
   logic [31:0] skid_data, skid_pc, skid_data_nx, skid_pc_nx;
   logic        skid_full, skid_full_nx;
   logic        load_valid;
   logic [31:0] pc_next_al;

   assign pc_next_al     = {PC_next[31:2], 2'b00};
   assign PC_plus4       = PC + 32'd4;
   assign imem.imem_addr = PC;
   assign imem.imem_req  = (state == S_FETCH);

   always_comb begin
      state_nx     = state;
      pc_nx        = PC;
      out_nx       = instr_out;
      ipc_nx       = instr_pc;
      valid_nx     = instr_valid;
      skid_data_nx = skid_data;
      skid_pc_nx   = skid_pc;
      skid_full_nx = skid_full;
      load_valid   = 1'b0;

      // Redirect wins over stall and any same-cycle response, except while booting.
      if (flush && state != S_BOOT) begin
         valid_nx     = 1'b0;
         out_nx       = NOP_INSTR;
         skid_full_nx = 1'b0;
         pc_nx        = pc_next_al;
         state_nx     = S_FETCH;
      end else begin
         case (state)
            S_BOOT: state_nx = S_FETCH;
            S_FETCH: begin
               if (!stall && imem.imem_ready) begin
                  out_nx     = imem.imem_rdata;
                  ipc_nx     = PC;
                  valid_nx   = 1'b1;
                  load_valid = 1'b1;
                  pc_nx      = pc_next_al;
               end else if (!stall) begin
                  valid_nx = 1'b0;
                  out_nx   = NOP_INSTR;
               end else if (imem.imem_ready) begin
                  skid_data_nx = imem.imem_rdata;
                  skid_pc_nx   = PC;
                  skid_full_nx = 1'b1;
                  state_nx     = S_HOLD;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  out_nx       = skid_data;
                  ipc_nx       = skid_pc;
                  valid_nx     = 1'b1;
                  load_valid   = 1'b1;
                  pc_nx        = pc_next_al;
                  skid_full_nx = 1'b0;
                  state_nx     = S_FETCH;
               end
            end
            default: state_nx = S_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_BOOT;
         PC          <= {RESET_PC[31:2], 2'b00};
         instr_out   <= NOP_INSTR;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         skid_data   <= '0;
         skid_pc     <= '0;
         skid_full   <= 1'b0;
      end else begin
         state       <= state_nx;
         PC          <= pc_nx;
         instr_out   <= out_nx;
         instr_pc    <= ipc_nx;
         instr_valid <= valid_nx;
         skid_data   <= skid_data_nx;
         skid_pc     <= skid_pc_nx;
         skid_full   <= skid_full_nx;
      end
   end

`ifdef FETCH_STAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_count  <= '0;
         stall_cycles <= '0;
      end else begin
         if (load_valid)
            fetch_count <= fetch_count + 32'd1;
         if (stall && state != S_BOOT)
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program counter register and instruction-fetch stage. It sits directly downstream of the PC-select mux and consumes that mux's PC_next.
- Holds the architectural PC and issues fetch requests to instruction memory over a req/ready handshake.
- Delivers each fetched instruction and its PC to decode through a registered IF/ID output with a one-entry skid buffer.
- Drives PC_plus4 back to the mux as its sequential (+4) candidate.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0000, value driven on instr_out at reset and on bubbles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- PC_next  in  32  next PC from PC-select mux; bits [1:0] ignored.
- stall  in  1  decode cannot accept; hold PC and IF/ID outputs.
- flush  in  1  redirect (taken branch/jump); kill buffered and in-flight fetch.
- imem_ready  in  1  instruction memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals PC.
- PC  out  32  current PC register.
- PC_plus4  out  32  combinational PC+4, fed to the mux.
- instr_out  out  32  IF/ID instruction.
- instr_pc  out  32  PC of instr_out.
- instr_valid  out  1  instr_out is a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; state=S_BOOT; imem_req=0; instr_valid=0.
  - instr_out=NOP_INSTR; instr_pc=0; skid buffer empty.
- States: S_BOOT, S_FETCH, S_HOLD.
- S_BOOT:
  - imem_req=0.
  - Go to S_FETCH unconditionally on the next edge, giving one idle cycle after reset release.
- S_FETCH:
  - imem_req=1; imem_addr=PC.
  - imem_ready=1 and stall=0:
    - instr_out<=imem_rdata; instr_pc<=PC; instr_valid<=1; PC<=PC_next.
    - Stay in S_FETCH. Sustained throughput is one instruction per cycle.
  - imem_ready=0 and stall=0: instr_valid<=0 (bubble, instr_out<=NOP_INSTR); PC holds.
  - imem_ready=1 and stall=1:
    - imem_rdata and PC are captured into the skid buffer.
    - IF/ID outputs hold; PC holds; go to S_HOLD.
  - imem_ready=0 and stall=1: everything holds.
- S_HOLD:
  - imem_req=0; IF/ID outputs hold while stall=1.
  - When stall=0: instr_out<=skid data; instr_pc<=skid PC; instr_valid<=1; PC<=PC_next; skid emptied; go to S_FETCH.
- flush (any state except S_BOOT):
  - Highest priority; overrides stall and imem_ready.
  - instr_valid<=0; instr_out<=NOP_INSTR; skid emptied; PC<=PC_next; go to S_FETCH.
  - A same-cycle imem_ready response is discarded.
- flush during S_BOOT is ignored.
- Latency: instruction appears on instr_out the cycle after the imem_ready/stall=0 edge.
- Arithmetic and alignment:
  - PC_plus4 = PC + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
  - Stored PC always has [1:0]=00; PC_next[1:0] is masked on load.
- The memory must not see a request change while waiting: imem_addr stays stable while imem_req=1 and imem_ready=0, because PC does not update.
- Reset mid-operation: immediate return to reset values; any in-flight response is discarded.

Optional Feature:
- Macro FETCH_STAT_EN.
- When defined:
  - Adds output fetch_count [31:0], reset 0.
  - It increments on every cycle in which instr_valid is loaded with 1, and wraps at 2^32.
  - Adds output stall_cycles [31:0], reset 0, which increments every cycle stall=1 and state≠S_BOOT.
- When undefined: neither port exists and no counter logic is built. Core behaviour is identical in both cases.

Test Plan:
- Reset release with RESET_PC=0: cycle 0 imem_req=0; cycle 1 imem_req=1, imem_addr=0. With imem_ready=1 and PC_next=PC_plus4 every cycle, instr_pc sequence is 0,4,8,12 with instr_valid=1 each cycle.
- Wait state: hold imem_ready=0 for 3 cycles at PC=0x10 → imem_addr stays 0x10, instr_valid=0 for 3 cycles; then ready with rdata=0x8C01_0004 → instr_out=0x8C01_0004, instr_pc=0x10.
- Stall plus skid:
  - At PC=0x20 with instr_out from 0x1C valid, assert stall for 2 cycles while imem_ready=1, rdata=0xAAAA_5555.
  - Required: instr_out holds the 0x1C instruction, imem_req=0 in the second cycle, PC=0x20.
  - After stall drops: instr_out=0xAAAA_5555, instr_pc=0x20, PC=PC_next=0x24.
- Flush: at PC=0x40 assert flush with PC_next=0x100 and imem_ready=1 → instr_valid=0, instr_out=NOP_INSTR, PC=0x100. Also flush while in S_HOLD → skid discarded, next instr_pc=0x100.
- Wrap and alignment:
  - PC=0xFFFF_FFFC gives PC_plus4=0x0000_0000.
  - Loading PC_next=0x0000_0203 gives PC=0x0000_0200.
- Async reset: assert rst_n=0 mid-cycle during S_HOLD → outputs reach reset values without waiting for a clock edge. With FETCH_STAT_EN defined, fetch_count=0 and stall_cycles=0 after reset, and fetch_count equals the number of valid instructions delivered in the first scenario.
